// File: rtl/fpga_config_loader.sv
// Bitstream loader for the fpga fabric.
// Takes configuration words over a valid/ready stream, drives the fabric's
// configs_in/configs_en bus one tile per word, then sequences ff_en and rdy
// once the settle and ready delays have elapsed. A start pulse in DONE (or
// ERROR) reloads the fabric without a reset.
// Optional feature macro: CFG_CHECKSUM_EN -- after the last tile one extra word
// is accepted and compared against the running XOR of all loaded words.
module fpga_config_loader #(
   parameter int unsigned CFG_W         = 224,
   parameter int unsigned NUM_TILES     = 43,
   parameter int unsigned EN_HOLD       = 2,
   parameter int unsigned SETTLE_CYCLES = 10,
   parameter int unsigned RDY_DELAY     = 10,
   localparam int unsigned IDX_W        = $clog2(NUM_TILES + 1)
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CFG_W-1:0]     cfg_data,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   output logic [CFG_W-1:0]     configs_in,
   output logic [NUM_TILES-1:0] configs_en,
   output logic                 ff_en,
   output logic                 rdy,
   output logic                 busy,
   output logic [IDX_W-1:0]     tile_idx,
   output logic                 cfg_err
);

   localparam int unsigned HOLD_W = $clog2(EN_HOLD + 1);
   // A zero settle interval still needs a one-bit counter to compare against.
   localparam int unsigned SET_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam int unsigned DLY_W  = $clog2(RDY_DELAY + 1);

`ifdef CFG_CHECKSUM_EN
   typedef enum logic [2:0] {
      StIdle, StLoad, StStrobe, StCheck, StSettle, StWaitRdy, StDone, StError
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle, StLoad, StStrobe, StSettle, StWaitRdy, StDone
   } state_e;
`endif

   state_e               state_q, state_d;
   logic [CFG_W-1:0]     configs_in_q, configs_in_d;
   logic [NUM_TILES-1:0] configs_en_q, configs_en_d;
   logic                 ff_en_q, ff_en_d;
   logic                 rdy_q, rdy_d;
   logic [IDX_W-1:0]     tile_idx_q, tile_idx_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic [SET_W-1:0]     settle_q, settle_d;
   logic [DLY_W-1:0]     dly_q, dly_d;
`ifdef CFG_CHECKSUM_EN
   logic [CFG_W-1:0]     csum_q, csum_d;
   logic                 cfg_err_q, cfg_err_d;
`endif

   // State and output registers; reset clears everything immediately, even mid-load.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         configs_in_q <= '0;
         configs_en_q <= '0;
         ff_en_q      <= 1'b0;
         rdy_q        <= 1'b0;
         tile_idx_q   <= '0;
         hold_q       <= '0;
         settle_q     <= '0;
         dly_q        <= '0;
`ifdef CFG_CHECKSUM_EN
         csum_q       <= '0;
         cfg_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         configs_in_q <= configs_in_d;
         configs_en_q <= configs_en_d;
         ff_en_q      <= ff_en_d;
         rdy_q        <= rdy_d;
         tile_idx_q   <= tile_idx_d;
         hold_q       <= hold_d;
         settle_q     <= settle_d;
         dly_q        <= dly_d;
`ifdef CFG_CHECKSUM_EN
         csum_q       <= csum_d;
         cfg_err_q    <= cfg_err_d;
`endif
      end
   end

   // Next-state logic plus the state-decoded cfg_ready/busy outputs.
   always_comb begin
      state_d      = state_q;
      configs_in_d = configs_in_q;
      configs_en_d = configs_en_q;
      ff_en_d      = ff_en_q;
      rdy_d        = rdy_q;
      tile_idx_d   = tile_idx_q;
      hold_d       = hold_q;
      settle_d     = settle_q;
      dly_d        = dly_q;
`ifdef CFG_CHECKSUM_EN
      csum_d       = csum_q;
      cfg_err_d    = cfg_err_q;
`endif
      cfg_ready    = 1'b0;
      busy         = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               tile_idx_d = '0;
`ifdef CFG_CHECKSUM_EN
               csum_d     = '0;
`endif
               state_d    = StLoad;
            end
         end

         StLoad: begin
            busy      = 1'b1;
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               configs_in_d = cfg_data;
               configs_en_d = NUM_TILES'(1) << tile_idx_q;
               if (tile_idx_q < IDX_W'(NUM_TILES)) begin
                  tile_idx_d = tile_idx_q + IDX_W'(1);
               end
               hold_d  = '0;
`ifdef CFG_CHECKSUM_EN
               csum_d  = csum_q ^ cfg_data;
`endif
               state_d = StStrobe;
            end
         end

         StStrobe: begin
            busy = 1'b1;
            if (hold_q == HOLD_W'(EN_HOLD - 1)) begin
               configs_en_d = '0;
               if (tile_idx_q < IDX_W'(NUM_TILES)) begin
                  state_d = StLoad;
               end else begin
`ifdef CFG_CHECKSUM_EN
                  state_d  = StCheck;
`else
                  settle_d = '0;
                  state_d  = StSettle;
`endif
               end
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end

`ifdef CFG_CHECKSUM_EN
         // The trailing word is consumed here and never strobed into the fabric.
         StCheck: begin
            busy      = 1'b1;
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               if (cfg_data == csum_q) begin
                  settle_d = '0;
                  state_d  = StSettle;
               end else begin
                  cfg_err_d = 1'b1;
                  state_d   = StError;
               end
            end
         end
`endif

         StSettle: begin
            busy = 1'b1;
            if (settle_q == SET_W'(SETTLE_CYCLES)) begin
               ff_en_d = 1'b1;
               dly_d   = '0;
               state_d = StWaitRdy;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end

         StWaitRdy: begin
            busy = 1'b1;
            if (dly_q == DLY_W'(RDY_DELAY - 1)) begin
               rdy_d   = 1'b1;
               state_d = StDone;
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end

         StDone: begin
            if (start) begin
               ff_en_d    = 1'b0;
               rdy_d      = 1'b0;
               tile_idx_d = '0;
`ifdef CFG_CHECKSUM_EN
               csum_d     = '0;
`endif
               state_d    = StLoad;
            end
         end

`ifdef CFG_CHECKSUM_EN
         StError: begin
            if (start) begin
               cfg_err_d  = 1'b0;
               tile_idx_d = '0;
               csum_d     = '0;
               state_d    = StLoad;
            end
         end
`endif

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign configs_in = configs_in_q;
   assign configs_en = configs_en_q;
   assign ff_en      = ff_en_q;
   assign rdy        = rdy_q;
   assign tile_idx   = tile_idx_q;
`ifdef CFG_CHECKSUM_EN
   assign cfg_err    = cfg_err_q;
`else
   assign cfg_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_config_loader.sv
// Bench for fpga_config_loader: a cycle-by-cycle vector table for the basic
// load / reload flow, then hand-written sequences for stretched streams,
// start pulses mid-load, asynchronous reset during a strobe and (with
// CFG_CHECKSUM_EN) the checksum pass/fail paths. A second instance with a zero
// settle interval runs in lockstep on the same inputs.
module tb_fpga_config_loader;

   localparam int unsigned W  = 8;
   localparam int unsigned NT = 4;
   localparam int unsigned IW = 3;

   logic          clock = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  cfg_data;
   logic          cfg_valid;

   logic          cfg_ready, ff_en, rdy, busy, cfg_err;
   logic [W-1:0]  configs_in;
   logic [NT-1:0] configs_en;
   logic [IW-1:0] tile_idx;

   logic          d1_cfg_ready, d1_ff_en, d1_rdy, d1_busy, d1_cfg_err;
   logic [W-1:0]  d1_configs_in;
   logic [NT-1:0] d1_configs_en;
   logic [IW-1:0] d1_tile_idx;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   fpga_config_loader #(
      .CFG_W(W), .NUM_TILES(NT), .EN_HOLD(2), .SETTLE_CYCLES(3), .RDY_DELAY(2)
   ) dut (
      .clock(clock), .rst(rst), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .configs_in(configs_in), .configs_en(configs_en),
      .ff_en(ff_en), .rdy(rdy), .busy(busy), .tile_idx(tile_idx), .cfg_err(cfg_err)
   );

   fpga_config_loader #(
      .CFG_W(W), .NUM_TILES(NT), .EN_HOLD(2), .SETTLE_CYCLES(0), .RDY_DELAY(2)
   ) dut_s0 (
      .clock(clock), .rst(rst), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
      .cfg_ready(d1_cfg_ready), .configs_in(d1_configs_in), .configs_en(d1_configs_en),
      .ff_en(d1_ff_en), .rdy(d1_rdy), .busy(d1_busy), .tile_idx(d1_tile_idx),
      .cfg_err(d1_cfg_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Strobe monitor: logs each new enable with its data and pulse length.
   logic [NT-1:0] en_log[$];
   logic [W-1:0]  din_log[$];
   int            len_log[$];
   logic [NT-1:0] prev_en = '0;
   int            run     = 0;

   always @(negedge clock) begin
      if (!rst) begin
         prev_en = '0;
         run     = 0;
      end else begin
         total++;
         if (!$onehot0(configs_en)) begin
            bad++;
            $display("FAIL onehot: configs_en=%b expected at most one bit", configs_en);
         end
         if (configs_en != '0 && configs_en != prev_en) begin
            if (prev_en != '0) len_log.push_back(run);
            en_log.push_back(configs_en);
            din_log.push_back(configs_in);
            run = 1;
         end else if (configs_en != '0) begin
            run++;
         end else if (prev_en != '0) begin
            len_log.push_back(run);
         end
         prev_en = configs_en;
      end
   end

   task automatic clear_logs();
      en_log.delete();
      din_log.delete();
      len_log.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   // Waits for cfg_ready, idles gap cycles with valid low, then hands over one word.
   task automatic send_word(input logic [W-1:0] w, input int gap);
      int n = 0;
      while (!cfg_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      chk("ready_wait", {31'd0, cfg_ready}, 32'd1);
      repeat (gap) begin
         @(posedge clock); #1;
      end
      cfg_valid = 1'b1;
      cfg_data  = w;
      @(posedge clock); #1;
      cfg_valid = 1'b0;
      cfg_data  = 8'h00;
   endtask

   task automatic send_four(input logic [31:0] ws, input int gap);
      for (int i = 0; i < 4; i++) send_word(ws[8*i +: 8], gap);
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (!rdy && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      chk("rdy_wait", {31'd0, rdy}, 32'd1);
   endtask

   task automatic check_stream(input string tag, input logic [31:0] ws);
      chk({tag, "_count"}, en_log.size(), 4);
      chk({tag, "_lens"}, len_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < en_log.size()) begin
            chk($sformatf("%s_en%0d", tag, i), {28'd0, en_log[i]}, 32'd1 << i);
            chk($sformatf("%s_data%0d", tag, i), {24'd0, din_log[i]}, {24'd0, ws[8*i +: 8]});
         end
         if (i < len_log.size()) chk($sformatf("%s_len%0d", tag, i), len_log[i], 2);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ready"}, {31'd0, cfg_ready}, 0);
      chk({tag, "_in"}, {24'd0, configs_in}, 0);
      chk({tag, "_en"}, {28'd0, configs_en}, 0);
      chk({tag, "_ff"}, {31'd0, ff_en}, 0);
      chk({tag, "_rdy"}, {31'd0, rdy}, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
      chk({tag, "_idx"}, {29'd0, tile_idx}, 0);
      chk({tag, "_err"}, {31'd0, cfg_err}, 0);
      chk({tag, "_s0_ff"}, {31'd0, d1_ff_en}, 0);
      chk({tag, "_s0_rdy"}, {31'd0, d1_rdy}, 0);
   endtask

   typedef struct packed {
      logic          start;
      logic          valid;
      logic [W-1:0]  data;
      logic          ready;
      logic [NT-1:0] en;
      logic [W-1:0]  din;
      logic          ff;
      logic          rdy;
      logic          busy;
      logic [IW-1:0] idx;
      logic          ff1;
      logic          rdy1;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(logic s, logic vl, logic [W-1:0] d, logic r, logic [NT-1:0] e,
                              logic [W-1:0] di, logic f, logic rd, logic b, logic [IW-1:0] ix,
                              logic f1, logic r1);
      return '{s, vl, d, r, e, di, f, rd, b, ix, f1, r1};
   endfunction

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      #2 rst = 1'b0;
      #1 check_zero("reset");
      @(posedge clock); @(posedge clock); #1;
      rst = 1'b1;

`ifndef CFG_CHECKSUM_EN
      //          st vl data  rdy en       din   ff rd bz idx ff1 rd1
      vecs.push_back(v(0, 1, 8'h99, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 0)); // idle ignores valid
      vecs.push_back(v(1, 0, 8'h00, 1, 4'b0000, 8'h00, 0, 0, 1, 0, 0, 0));
      vecs.push_back(v(0, 1, 8'h11, 0, 4'b0001, 8'h11, 0, 0, 1, 1, 0, 0));
      vecs.push_back(v(0, 1, 8'h22, 0, 4'b0001, 8'h11, 0, 0, 1, 1, 0, 0));
      vecs.push_back(v(0, 1, 8'h22, 1, 4'b0000, 8'h11, 0, 0, 1, 1, 0, 0));
      vecs.push_back(v(0, 1, 8'h22, 0, 4'b0010, 8'h22, 0, 0, 1, 2, 0, 0));
      vecs.push_back(v(0, 1, 8'h33, 0, 4'b0010, 8'h22, 0, 0, 1, 2, 0, 0));
      vecs.push_back(v(0, 1, 8'h33, 1, 4'b0000, 8'h22, 0, 0, 1, 2, 0, 0));
      vecs.push_back(v(0, 1, 8'h33, 0, 4'b0100, 8'h33, 0, 0, 1, 3, 0, 0));
      vecs.push_back(v(0, 1, 8'h44, 0, 4'b0100, 8'h33, 0, 0, 1, 3, 0, 0));
      vecs.push_back(v(0, 1, 8'h44, 1, 4'b0000, 8'h33, 0, 0, 1, 3, 0, 0));
      vecs.push_back(v(0, 1, 8'h44, 0, 4'b1000, 8'h44, 0, 0, 1, 4, 0, 0));
      vecs.push_back(v(0, 1, 8'h55, 0, 4'b1000, 8'h44, 0, 0, 1, 4, 0, 0));
      vecs.push_back(v(0, 1, 8'h55, 0, 4'b0000, 8'h44, 0, 0, 1, 4, 0, 0)); // settle starts
      vecs.push_back(v(0, 1, 8'h55, 0, 4'b0000, 8'h44, 0, 0, 1, 4, 1, 0));
      vecs.push_back(v(0, 0, 8'h00, 0, 4'b0000, 8'h44, 0, 0, 1, 4, 1, 0));
      vecs.push_back(v(0, 0, 8'h00, 0, 4'b0000, 8'h44, 0, 0, 1, 4, 1, 1));
      vecs.push_back(v(0, 0, 8'h00, 0, 4'b0000, 8'h44, 1, 0, 1, 4, 1, 1)); // ff_en +4
      vecs.push_back(v(0, 0, 8'h00, 0, 4'b0000, 8'h44, 1, 0, 1, 4, 1, 1));
      vecs.push_back(v(0, 0, 8'h00, 0, 4'b0000, 8'h44, 1, 1, 0, 4, 1, 1)); // rdy +2
      vecs.push_back(v(0, 0, 8'h00, 0, 4'b0000, 8'h44, 1, 1, 0, 4, 1, 1));
      vecs.push_back(v(1, 0, 8'h00, 1, 4'b0000, 8'h44, 0, 0, 1, 0, 0, 0)); // reload
      vecs.push_back(v(1, 0, 8'h00, 1, 4'b0000, 8'h44, 0, 0, 1, 0, 0, 0)); // start in LOAD

      foreach (vecs[i]) begin
         start     = vecs[i].start;
         cfg_valid = vecs[i].valid;
         cfg_data  = vecs[i].data;
         @(posedge clock); #1;
         chk($sformatf("row%0d_ready", i), {31'd0, cfg_ready}, {31'd0, vecs[i].ready});
         chk($sformatf("row%0d_en", i), {28'd0, configs_en}, {28'd0, vecs[i].en});
         chk($sformatf("row%0d_din", i), {24'd0, configs_in}, {24'd0, vecs[i].din});
         chk($sformatf("row%0d_ff", i), {31'd0, ff_en}, {31'd0, vecs[i].ff});
         chk($sformatf("row%0d_rdy", i), {31'd0, rdy}, {31'd0, vecs[i].rdy});
         chk($sformatf("row%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
         chk($sformatf("row%0d_idx", i), {29'd0, tile_idx}, {29'd0, vecs[i].idx});
         chk($sformatf("row%0d_err", i), {31'd0, cfg_err}, 0);
         chk($sformatf("row%0d_s0_ff", i), {31'd0, d1_ff_en}, {31'd0, vecs[i].ff1});
         chk($sformatf("row%0d_s0_rdy", i), {31'd0, d1_rdy}, {31'd0, vecs[i].rdy1});
      end
      start     = 1'b0;
      cfg_valid = 1'b0;

      // Finish the reload with new words.
      clear_logs();
      send_four(32'hA3A2A1A0, 0);
      wait_rdy();
      check_stream("reload", 32'hA3A2A1A0);
      chk("reload_idx", {29'd0, tile_idx}, 4);
      chk("reload_ff", {31'd0, ff_en}, 1);

      // Stretched stream with a start pulse during a strobe, which must be ignored.
      clear_logs();
      pulse_start();
      send_word(8'h11, 2);
      pulse_start();
      send_word(8'h22, 2);
      send_word(8'h33, 2);
      send_word(8'h44, 2);
      wait_rdy();
      check_stream("stretch", 32'h44332211);
      chk("stretch_idx", {29'd0, tile_idx}, 4);

      // Asynchronous reset during the third strobe, then a clean reload.
      clear_logs();
      pulse_start();
      send_word(8'h11, 0);
      send_word(8'h22, 0);
      send_word(8'h33, 0);
      chk("pre_rst_en", {28'd0, configs_en}, 32'b0100);
      #2 rst = 1'b0;
      #1 check_zero("midrst");
      @(posedge clock); #1;
      rst = 1'b1;
      @(posedge clock); #1;
      chk("post_rst_ready", {31'd0, cfg_ready}, 0);
      clear_logs();
      pulse_start();
      send_four(32'h8D7C6B5A, 0);
      wait_rdy();
      check_stream("after_rst", 32'h8D7C6B5A);
`else
      // Good checksum: 11^22^33^44 = 44.
      pulse_start();
      send_four(32'h44332211, 0);
      send_word(8'h44, 0);
      wait_rdy();
      chk("csum_ok_err", {31'd0, cfg_err}, 0);
      chk("csum_ok_ff", {31'd0, ff_en}, 1);

      // Bad checksum word.
      pulse_start();
      send_four(32'h44332211, 0);
      send_word(8'h45, 0);
      chk("csum_bad_err", {31'd0, cfg_err}, 1);
      chk("csum_bad_ff", {31'd0, ff_en}, 0);
      chk("csum_bad_rdy", {31'd0, rdy}, 0);
      chk("csum_bad_busy", {31'd0, busy}, 0);
      @(posedge clock); #1;
      chk("csum_bad_hold", {31'd0, cfg_err}, 1);

      // Start clears the error and the running checksum.
      pulse_start();
      chk("csum_clr_err", {31'd0, cfg_err}, 0);
      chk("csum_clr_busy", {31'd0, busy}, 1);
      send_four(32'h44332211, 0);
      send_word(8'h44, 0);
      wait_rdy();
      chk("csum_reload_err", {31'd0, cfg_err}, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
